// File: rtl/blowfish_pkg.sv
// blowfish_pkg: shared types and widths for the Blowfish Feistel core
package blowfish_pkg;
    localparam int P_ENTRIES = 18;
    localparam int P_IDX_W   = 5;
    localparam int SB_IDX_W  = 8;
    localparam int WORD_W    = 32;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;
    typedef enum logic [2:0] {IDLE, XOR_P, F_APPLY, FIN_R, FIN_L, DONE} state_t;
endpackage

// File: rtl/blowfish_feistel_core_f_comb.sv
// blowfish_f_comb: splits xL into S-box byte indices and folds the four S-box words into F
module blowfish_f_comb
    import blowfish_pkg::*;
(
    input  logic                en,
    input  logic [WORD_W-1:0]   xl,
    input  logic [WORD_W-1:0]   sb0_word,
    input  logic [WORD_W-1:0]   sb1_word,
    input  logic [WORD_W-1:0]   sb2_word,
    input  logic [WORD_W-1:0]   sb3_word,
    output logic [SB_IDX_W-1:0] sb0_idx,
    output logic [SB_IDX_W-1:0] sb1_idx,
    output logic [SB_IDX_W-1:0] sb2_idx,
    output logic [SB_IDX_W-1:0] sb3_idx,
    output logic [WORD_W-1:0]   f
);
    assign {sb0_idx, sb1_idx, sb2_idx, sb3_idx} = en ? xl : '0;
    assign f = ((sb0_word + sb1_word) ^ sb2_word) + sb3_word;
endmodule

// File: rtl/blowfish_feistel_core.sv
// blowfish_feistel_core: iterative Blowfish Feistel engine, one round per two cycles,
// P-array and S-boxes looked up externally with same-cycle combinational return
module blowfish_feistel_core
    import blowfish_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [63:0]         in_block,
    output logic [P_IDX_W-1:0]  p_idx,
    input  logic [WORD_W-1:0]   p_word,
    output logic [SB_IDX_W-1:0] sb0_idx,
    output logic [SB_IDX_W-1:0] sb1_idx,
    output logic [SB_IDX_W-1:0] sb2_idx,
    output logic [SB_IDX_W-1:0] sb3_idx,
    input  logic [WORD_W-1:0]   sb0_word,
    input  logic [WORD_W-1:0]   sb1_word,
    input  logic [WORD_W-1:0]   sb2_word,
    input  logic [WORD_W-1:0]   sb3_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         out_block,
    output logic                busy
);
    localparam logic [3:0] RND_LAST = 4'(ROUNDS - 1);
    localparam logic [P_IDX_W-1:0] P_LAST = P_IDX_W'(P_ENTRIES - 1);
    localparam logic [P_IDX_W-1:0] P_ENC_R = P_IDX_W'(P_ENTRIES - 2);
    localparam logic [P_IDX_W-1:0] P_DEC_R = P_IDX_W'(1);
    state_t state;
    logic [WORD_W-1:0] xl, xr, f;
    logic [3:0] rnd;
    logic mode, dec;
    assign dec = mode == MODE_DEC;
    // decrypt walks the P-array backwards: rounds use 17..2, whitening uses 1 then 0
    always_comb
        p_idx = state == XOR_P ? (dec ? P_LAST - P_IDX_W'(rnd) : P_IDX_W'(rnd)) :
                state == FIN_R ? (dec ? P_DEC_R : P_ENC_R) :
                state == FIN_L ? (dec ? '0 : P_LAST) : '0;
    blowfish_f_comb u_f (
        .en(state == F_APPLY), .xl(xl),
        .sb0_word(sb0_word), .sb1_word(sb1_word), .sb2_word(sb2_word), .sb3_word(sb3_word),
        .sb0_idx(sb0_idx), .sb1_idx(sb1_idx), .sb2_idx(sb2_idx), .sb3_idx(sb3_idx),
        .f(f)
    );
    assign out_block = out_valid ? {xl, xr} : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            xl        <= '0;
            xr        <= '0;
            rnd       <= '0;
            mode      <= MODE_ENC;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    {xl, xr} <= in_block;
                    mode     <= in_mode;
                    rnd      <= '0;
                    state    <= XOR_P;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                XOR_P: begin
                    xl    <= xl ^ p_word;
                    state <= F_APPLY;
                end
                F_APPLY: if (rnd == RND_LAST) begin
                    xr    <= xr ^ f;
                    state <= FIN_R;
                end else begin
                    xl    <= xr ^ f;
                    xr    <= xl;
                    rnd   <= rnd + 4'd1;
                    state <= XOR_P;
                end
                FIN_R: begin
                    xr    <= xr ^ p_word;
                    state <= FIN_L;
                end
                FIN_L: begin
                    xl        <= xl ^ p_word;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blowfish_feistel_core.sv
// tb_blowfish_feistel_core: directed vectors against a textbook Blowfish model with
// bench-owned P/S tables, checked every cycle of every block
module tb_blowfish_feistel_core;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, busy;
    logic [63:0] in_block = '0, out_block;
    logic [4:0] p_idx;
    logic [31:0] p_word, sb0_word, sb1_word, sb2_word, sb3_word;
    logic [7:0] sb0_idx, sb1_idx, sb2_idx, sb3_idx;
    logic [31:0] pa [18];
    logic [31:0] sb [4][256];
    int n_chk = 0, n_pass = 0, cyc = 0;
    int run_id = 0, seen_id = 0, kill = 0, acc_cyc = 0, hs_cyc = 0;
    logic fin_mode = 1'b0;
    logic [63:0] exp_out = '0, last_out = '0, res;
    logic [4:0] exp_p [16];
    logic [31:0] exp_xl [16];
    logic [63:0] vec [4] = '{64'h0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'hDEADBEEFCAFEF00D};

    blowfish_feistel_core #(.ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_block(in_block), .p_idx(p_idx), .p_word(p_word),
        .sb0_idx(sb0_idx), .sb1_idx(sb1_idx), .sb2_idx(sb2_idx), .sb3_idx(sb3_idx),
        .sb0_word(sb0_word), .sb1_word(sb1_word), .sb2_word(sb2_word), .sb3_word(sb3_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign p_word = p_idx < 5'd18 ? pa[p_idx] : 32'hDEADBEEF;
    assign sb0_word = sb[0][sb0_idx];
    assign sb1_word = sb[1][sb1_idx];
    assign sb2_word = sb[2][sb2_idx];
    assign sb3_word = sb[3][sb3_idx];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mix(input logic [31:0] x);
        x ^= x << 13;
        x ^= x >> 17;
        x ^= x << 5;
        return x * 32'h9E3779B1;
    endfunction

    function automatic logic [31:0] ff(input logic [31:0] x);
        return ((sb[0][x[31:24]] + sb[1][x[23:16]]) ^ sb[2][x[15:8]]) + sb[3][x[7:0]];
    endfunction

    // kind 0: all zero, 1: only P[17] = all ones, 2: pseudo-random index-derived tables
    task automatic load(input int kind);
        for (int i = 0; i < 18; i++)
            pa[i] = kind == 2 ? mix(32'(i + 1)) : (kind == 1 && i == 17) ? 32'hFFFFFFFF : 32'h0;
        for (int t = 0; t < 4; t++)
            for (int j = 0; j < 256; j++)
                sb[t][j] = kind == 2 ? mix(32'(t * 256 + j + 100)) : 32'h0;
    endtask

    // textbook Blowfish: xor P, xR ^= F(xL), swap; undo last swap; whiten with the final two P
    task automatic model(input logic [63:0] blk, input logic m, output logic [63:0] r_out);
        logic [31:0] l, r, t;
        int pi;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < 16; i++) begin
            pi = m ? 17 - i : i;
            exp_p[i] = 5'(pi);
            l ^= pa[pi];
            exp_xl[i] = l;
            r ^= ff(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r ^= pa[m ? 1 : 16];
        l ^= pa[m ? 0 : 17];
        r_out = {l, r};
    endtask

    task automatic compare_step();
        int k;
        if (run_id != seen_id && run_id != kill) begin
            k = cyc - acc_cyc;
            if (k < 32) begin
                chk("p_idx", 64'(k % 2 == 0 ? exp_p[k / 2] : 5'd0), 64'(p_idx));
                chk("sb_idx", 64'({sb0_idx, sb1_idx, sb2_idx, sb3_idx}),
                    64'(k % 2 == 1 ? exp_xl[k / 2] : 32'd0));
            end else if (k < 34) begin
                chk("p_idx_fin", 64'(p_idx),
                    64'(k == 32 ? (fin_mode ? 5'd1 : 5'd16) : (fin_mode ? 5'd0 : 5'd17)));
            end
            if (k < 34) chk("flags_run", 64'({out_valid, busy, in_ready}), 64'(3'b010));
            else begin
                chk("flags_done", 64'({out_valid, busy, in_ready}), 64'(3'b110));
                chk("out_block", out_block, exp_out);
                if (out_ready) begin
                    seen_id = run_id;
                    hs_cyc = cyc + 1;
                    last_out = out_block;
                end
            end
        end
    endtask

    task automatic launch(input logic [63:0] b, input logic m);
        logic r;
        bit got = 0;
        in_block = b;
        in_mode = m;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            r = in_ready;
            @(posedge clk); #1;
            if (r) got = 1;
        end
        in_valid = 1'b0;
        chk("accept", 64'(got), 64'd1);
        model(b, m, exp_out);
        fin_mode = m;
        acc_cyc = cyc;
        run_id++;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && seen_id != run_id; i++) begin
            @(posedge clk); #1;
        end
        chk("done_wait", 64'(seen_id == run_id), 64'd1);
    endtask

    task automatic run(input logic [63:0] b, input logic m);
        launch(b, m);
        wait_done();
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                compare_step();
            end
        join_none
        load(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", 64'({out_valid, busy, in_ready}), 64'(3'b001));
        chk("rst_block", out_block, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        model(64'h0123456789ABCDEF, 1'b0, res);
        chk("model_zero", res, 64'h89ABCDEF01234567);
        run(64'h0123456789ABCDEF, 1'b0);
        chk("zero_tables", last_out, 64'h89ABCDEF01234567);
        load(1);
        model(64'h0, 1'b0, res);
        chk("model_p17_enc", res, 64'hFFFFFFFF00000000);
        // P[17] enters round 0 of decrypt and rides 15 swaps into xR
        model(64'h0, 1'b1, res);
        chk("model_p17_dec", res, 64'h00000000FFFFFFFF);
        run(64'h0, 1'b0);
        chk("p17_enc", last_out, 64'hFFFFFFFF00000000);
        run(64'h0, 1'b1);
        chk("p17_dec", last_out, 64'h00000000FFFFFFFF);
        load(2);
        for (int v = 0; v < 4; v++) begin
            launch(vec[v], 1'b0);
            in_mode = 1'b1;
            wait_done();
            run(last_out, 1'b1);
            chk("roundtrip", last_out, vec[v]);
        end
        out_ready = 1'b0;
        launch(vec[1], 1'b0);
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        in_block = vec[2];
        in_mode = 1'b1;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        launch(vec[2], 1'b1);
        chk("accept_gap", 64'(acc_cyc - hs_cyc), 64'd1);
        wait_done();
        launch(vec[3], 1'b0);
        repeat (12) @(posedge clk);
        #1;
        kill = run_id;
        rst = 1'b1;
        #1;
        chk("async_rst_flags", 64'({out_valid, busy, in_ready}), 64'(3'b001));
        chk("async_rst_block", out_block, 64'h0);
        chk("async_rst_pidx", 64'(p_idx), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(vec[3], 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
